// File: rtl/vga_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared 640x480@60 raster constants for the timing generator,
//            renderer and game logic.
// Contents : Timing constants, derived totals and sync windows, and the
//            10-bit coordinate width and type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing, pixels
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  // Vertical timing, lines
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Derived values; sync windows are half-open [START, END)
  localparam int H_TOTAL  = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL  = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int HS_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int HS_END   = HS_START + VGA_H_SYNC;
  localparam int VS_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VS_END   = VS_START + VGA_V_SYNC;

endpackage
`default_nettype wire

// File: rtl/pix_clk_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pix_clk_div
// Purpose  : Free-running divider producing a pixel-advance strobe once
//            every PIX_DIV clocks.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            o_pix_en - high on the last clock of each pixel period
// Revision : 1.0 - initial release
// ============================================================================
module pix_clk_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_pix_en
);

  localparam int c_div_w = $clog2(PIX_DIV);

  logic [c_div_w-1:0] r_div;

  // PIX_DIV is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_div_w'(1);
    end
  end

  assign o_pix_en = (r_div == c_div_w'(PIX_DIV - 1));

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator: pixel/line counters, visible-area flag,
//            sync pins and a one-clock frame_start pulse.
// Ports    : clk           - system clock, rising edge
//            rst_n         - asynchronous active-low reset
//            o_pix_en      - pixel-advance strobe
//            o_h_counter   - current column, 0..H_TOTAL-1
//            o_v_counter   - current line,   0..V_TOTAL-1
//            o_vidon       - inside the visible area
//            o_hsync       - horizontal sync, level SYNC_POL when active
//            o_vsync       - vertical sync,   level SYNC_POL when active
//            o_frame_start - one-clock pulse when counters become (0,0)
// Config   : define VGA_PIXDIV_EN to divide clk by PIX_DIV for the pixel
//            rate; otherwise clk is the pixel clock and o_pix_en is 1.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter int   PIX_DIV   = 4,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_pix_en,
  output logic [COORD_W-1:0] o_h_counter,
  output logic [COORD_W-1:0] o_v_counter,
  output logic               o_vidon,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_frame_start
);

  localparam int c_h_total = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t c_h_last   = coord_t'(c_h_total - 1);
  localparam coord_t c_v_last   = coord_t'(c_v_total - 1);
  localparam coord_t c_h_vis    = coord_t'(H_VISIBLE);
  localparam coord_t c_v_vis    = coord_t'(V_VISIBLE);
  localparam coord_t c_hs_start = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t c_hs_end   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t c_vs_start = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t c_vs_end   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  logic   w_pix_en;
  coord_t w_h_next;
  coord_t w_v_next;

  coord_t r_h;
  coord_t r_v;
  logic   r_vidon;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_frame_start;

`ifdef VGA_PIXDIV_EN
  if (1) begin : g_pix_div
    pix_clk_div #(
      .PIX_DIV (PIX_DIV)
    ) u_pix_clk_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .o_pix_en (w_pix_en)
    );
  end
`else
  // clk already runs at the pixel rate.
  assign w_pix_en = 1'b1;
`endif

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_pix_en) begin
      if (r_h == c_h_last) begin
        w_h_next = '0;
        w_v_next = (r_v == c_v_last) ? '0 : r_v + coord_t'(1);
      end else begin
        w_h_next = r_h + coord_t'(1);
      end
    end
  end

  // Flags are decoded from the next counter values so that, once registered,
  // they line up with the counters presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h           <= c_h_last;
      r_v           <= c_v_last;
      r_vidon       <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_vidon       <= (w_h_next < c_h_vis) && (w_v_next < c_v_vis);
      r_hsync       <= ((w_h_next >= c_hs_start) && (w_h_next < c_hs_end))
                       ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= ((w_v_next >= c_vs_start) && (w_v_next < c_vs_end))
                       ? SYNC_POL : ~SYNC_POL;
      // Gated by the strobe so the pulse covers only the first clock of (0,0).
      r_frame_start <= w_pix_en && (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign o_pix_en      = w_pix_en;
  assign o_h_counter   = r_h;
  assign o_v_counter   = r_v;
  assign o_vidon       = r_vidon;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire
